// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM command initiator family.
package avmm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDV  = 3'd3,
    RESP = 3'd4
  } avmm_state_t;

  localparam logic [31:0] AVMM_ERR_RDATA = 32'h0;

  localparam logic AVMM_OP_RD = 1'b0;
  localparam logic AVMM_OP_WR = 1'b1;

  localparam int AVMM_CNT_W = 16;

endpackage

// File: rtl/avmm_timeout_cnt.sv
// Clear/enable up-counter with a terminal flag at TIMEOUT-1; clear has priority over enable.
module avmm_timeout_cnt
  import avmm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [AVMM_CNT_W-1:0] TC_VAL = AVMM_CNT_W'(TIMEOUT - 1);

  logic [AVMM_CNT_W-1:0] count;

  // Count cycles spent waiting on the bus; restarts on every new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + AVMM_CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/avmm_cmd_master.sv
// Single-outstanding Avalon-MM initiator: one fabric command in, one bus
// transaction out, one response back, with a timeout against hung slaves.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WR    | avm_write asserted until waitrequest drops or timeout
// RD    | avm_read asserted until waitrequest drops or timeout
// RDV   | read accepted, waiting for readdatavalid or timeout
// RESP  | response held until rsp_ready
module avmm_cmd_master
  import avmm_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  avmm_state_t       state, state_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [DATA_W-1:0] writedata_nxt;
  logic              read_nxt, write_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              cnt_clr, cnt_en, cnt_tc;

  avmm_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  // Gated with rst_n so the fabric never sees ready while reset is held.
  assign cmd_ready = rst_n && (state == IDLE);

  // Next-state and next-output decode; every registered output holds by default.
  always_comb begin
    state_nxt     = state;
    address_nxt   = avm_address;
    writedata_nxt = avm_writedata;
    read_nxt      = avm_read;
    write_nxt     = avm_write;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cnt_clr     = 1'b1;
          address_nxt = cmd_addr;
          if (cmd_write == AVMM_OP_WR) begin
            writedata_nxt = cmd_wdata;
            write_nxt     = 1'b1;
            state_nxt     = WR;
          end else begin
            writedata_nxt = '0;
            read_nxt      = 1'b1;
            state_nxt     = RD;
          end
        end
      end

      WR: begin
        cnt_en = 1'b1;
        if (!avm_waitrequest) begin
          write_nxt     = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RESP;
        end else if (cnt_tc) begin
          write_nxt     = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = DATA_W'(AVMM_ERR_RDATA);
          rsp_err_nxt   = 1'b1;
          state_nxt     = RESP;
        end
      end

      RD: begin
        cnt_en = 1'b1;
        // Only a full completion beats the timeout; a bare accept at the
        // terminal count still times out.
        if (!avm_waitrequest && avm_readdatavalid) begin
          read_nxt      = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = avm_readdata;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RESP;
        end else if (cnt_tc) begin
          read_nxt      = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = DATA_W'(AVMM_ERR_RDATA);
          rsp_err_nxt   = 1'b1;
          state_nxt     = RESP;
        end else if (!avm_waitrequest) begin
          read_nxt  = 1'b0;
          state_nxt = RDV;
        end
      end

      RDV: begin
        cnt_en = 1'b1;
        if (avm_readdatavalid) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = avm_readdata;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RESP;
        end else if (cnt_tc) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = DATA_W'(AVMM_ERR_RDATA);
          rsp_err_nxt   = 1'b1;
          state_nxt     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;
        rsp_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered bus and response outputs; reset clears everything, dropping any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      avm_address   <= address_nxt;
      avm_writedata <= writedata_nxt;
      avm_read      <= read_nxt;
      avm_write     <= write_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      rsp_err       <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master: table of single transactions plus
// hand-written timeout, back-pressure and reset sequences.
module tb_avmm_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest, avm_readdatavalid;

  int errors = 0;
  int checks = 0;

  avmm_cmd_master #(
    .ADDR_W (3),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    int          waits;    // waitrequest cycles before acceptance
    int          rdv_dly;  // cycles from acceptance to readdatavalid
    logic [31:0] rdata;
    int          exp_cyc;  // rsp_valid cycle relative to acceptance
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 30 && cmd_ready !== 1'b1; i++) tick();
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int          rsp_cyc;
    int          strobes;
    int          bad;
    logic [31:0] got_rdata;
    logic        got_err, got_cr;
    rsp_cyc = 0; strobes = 0; bad = 0;
    got_rdata = '0; got_err = 1'b0; got_cr = 1'b0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_cyc != 0 && c == rsp_cyc + 1) begin
        chk($sformatf("v%0d_ready_after", idx), 32'(cmd_ready), 32'd1);
        break;
      end
      if (avm_write || avm_read) begin
        strobes++;
        if (avm_address !== v.addr || avm_write !== v.wr || avm_read !== !v.wr ||
            (v.wr && avm_writedata !== v.wdata))
          bad++;
      end
      if (rsp_valid && rsp_cyc == 0) begin
        rsp_cyc   = c;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        got_cr    = cmd_ready;
      end
      avm_waitrequest   = (c <= v.waits);
      avm_readdatavalid = !v.wr && (c == v.waits + 1 + v.rdv_dly);
      avm_readdata      = avm_readdatavalid ? v.rdata : (32'hDEAD_0000 | 32'(c));
      tick();
    end
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    chk($sformatf("v%0d_rsp_cycle", idx), 32'(rsp_cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), 32'(got_err), 32'd0);
    chk($sformatf("v%0d_ready_in_resp", idx), 32'(got_cr), 32'd0);
    chk($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'(v.waits + 1));
    chk($sformatf("v%0d_bus_stable", idx), 32'(bad), 32'd0);
  endtask

  initial begin
    int strobes;
    int rsp_cyc;
    int bad;

    vecs[0] = '{1'b1, 3'd3, 32'hA5A5_0001, 0, 0, 32'h0,         2, 32'h0};
    vecs[1] = '{1'b0, 3'd5, 32'h0,         4, 2, 32'h1234_5678, 8, 32'h1234_5678};
    vecs[2] = '{1'b0, 3'd6, 32'h0,         0, 0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 3'd0, 32'h0,         0, 1, 32'h0BAD_BEEF, 3, 32'h0BAD_BEEF};
    vecs[4] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 3, 0, 32'h0,         5, 32'h0};
    vecs[5] = '{1'b0, 3'd2, 32'h0,         2, 3, 32'h8000_0001, 7, 32'h8000_0001};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;

    // Reset state.
    tick(); tick();
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_outputs", {24'(0), avm_address, avm_read, avm_write, rsp_valid, rsp_err},
        32'd0);
    chk("reset_data", avm_writedata | rsp_rdata, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Table of single transactions.
    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Timeout on a stuck write, then a stray readdatavalid while RESP is held.
    wait_ready();
    rsp_ready = 1'b0;
    avm_waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 32'h1111_2222;
    tick();
    cmd_valid = 1'b0;
    strobes = 0; rsp_cyc = 0;
    for (int c = 1; c <= 30 && rsp_cyc == 0; c++) begin
      if (avm_write) strobes++;
      if (rsp_valid) rsp_cyc = c;
      else tick();
    end
    chk("to_strobe_cycles", 32'(strobes), 32'd16);
    chk("to_rsp_cycle", 32'(rsp_cyc), 32'd17);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'h0);
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h7777_7777;
    tick();
    avm_readdatavalid = 1'b0;
    chk("stray_resp_rdata", rsp_rdata, 32'h0);
    chk("stray_resp_hold", {30'(0), rsp_valid, rsp_err}, 32'd3);
    rsp_ready = 1'b1;
    tick();
    chk("to_handshake", {30'(0), rsp_valid, cmd_ready}, 32'd1);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h6666_6666;
    tick();
    avm_readdatavalid = 1'b0;
    chk("stray_idle", {29'(0), rsp_valid, avm_read, cmd_ready}, 32'd1);

    // Response back-pressure: rsp_ready low for 5 cycles with a new command waiting.
    wait_ready();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; cmd_wdata = '0;
    tick();
    cmd_valid = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h55AA_33CC;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_wdata = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_rdata_%0d", i), rsp_rdata, 32'h55AA_33CC);
      chk($sformatf("bp_hold_ctl_%0d", i),
          {29'(0), rsp_valid, cmd_ready, avm_write}, 32'd4);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_after_handshake", {29'(0), rsp_valid, cmd_ready, avm_write}, 32'd2);
    tick();
    cmd_valid = 1'b0;
    chk("bp_new_write", {28'(0), avm_write, avm_address}, 32'h9);
    chk("bp_new_wdata", avm_writedata, 32'h0F0F_0F0F);
    tick();
    chk("bp_new_rsp", {30'(0), rsp_valid, rsp_err}, 32'd2);
    tick();

    // Reset while waiting in RDV.
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rdv_strobe_low", {30'(0), avm_read, cmd_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {24'(0), avm_address, cmd_ready, avm_read, avm_write, rsp_valid}, 32'd0);
    chk("async_reset_data", avm_writedata | rsp_rdata | 32'(rsp_err), 32'd0);
    tick(); tick();
    #3 rst_n = 1'b1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h9999_9999;
    tick();
    avm_readdatavalid = 1'b0;
    chk("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) bad++;
      tick();
    end
    chk("no_rsp_after_reset", 32'(bad), 32'd0);

    run_txn(6, vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
